// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants used by the fetch stage.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// In-order buffer of fetched {pc, instr} entries with single-cycle flush.
module ifetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  // A flush wins over both push and pop in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/ifetch_unit.sv
// RV32I fetch stage: credit-limited word requests to imem, in-order buffering,
// and redirect handling that discards responses still in flight.
module ifetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  logic            req_reg, req_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]   inflight_reg, inflight_next;
  logic [CW-1:0]   discard_reg, discard_next;
  logic            stale_reg, stale_next;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] base_pc;
  logic            gfire, pending, accept, drop, push, pop;
  logic            credit_ok, new_issue;
  logic [CW-1:0]   fifo_count, count_next;
  logic [SW-1:0]   credit_sum;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    head, push_entry;

  assign target     = word_align(redirect_pc);
  assign gfire      = req_reg & imem_gnt;
  assign pending    = req_reg & ~imem_gnt;
  assign accept     = imem_rvalid & (discard_reg == '0);
  assign drop       = imem_rvalid & (discard_reg != '0);
  assign push       = accept & ~redirect_valid;
  assign pop        = ~fifo_empty & id_ready;
  assign push_entry = '{pc: resp_pc_reg, instr: imem_rdata};

  always_comb begin
    inflight_next = inflight_reg;
    discard_next  = discard_reg;
    count_next    = fifo_count;
    if (redirect_valid) begin
      inflight_next = '0;
      discard_next  = discard_reg - CW'(drop) + inflight_reg + CW'(gfire) - CW'(accept);
      count_next    = '0;
    end else begin
      // A grant for a request issued before a redirect belongs to the discard pool.
      inflight_next = inflight_reg + CW'(gfire & ~stale_reg) - CW'(accept);
      discard_next  = discard_reg - CW'(drop) + CW'(gfire & stale_reg);
      count_next    = fifo_count + CW'(push) - CW'(pop);
    end
    // Discards are charged against credit too, which keeps every counter bounded.
    credit_sum    = SW'(count_next) + SW'(inflight_next) + SW'(discard_next);
    credit_ok     = credit_sum < SW'(DEPTH);
    new_issue     = ~pending & credit_ok;
    req_next      = pending | credit_ok;
    base_pc       = redirect_valid ? target : fetch_pc_reg;
    addr_next     = pending ? addr_reg : base_pc;
    fetch_pc_next = new_issue ? base_pc + 32'd4 : base_pc;
    stale_next    = pending & (stale_reg | redirect_valid);
    resp_pc_next  = redirect_valid ? target : (push ? resp_pc_reg + 32'd4 : resp_pc_reg);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_reg      <= 1'b0;
      addr_reg     <= RESET_PC;
      fetch_pc_reg <= RESET_PC;
      resp_pc_reg  <= RESET_PC;
      inflight_reg <= '0;
      discard_reg  <= '0;
      stale_reg    <= 1'b0;
    end else begin
      assert (!(imem_rvalid && inflight_reg == '0 && discard_reg == '0));
      assert (!(push && fifo_full && !pop));
      req_reg      <= req_next;
      addr_reg     <= addr_next;
      fetch_pc_reg <= fetch_pc_next;
      resp_pc_reg  <= resp_pc_next;
      inflight_reg <= inflight_next;
      discard_reg  <= discard_next;
      stale_reg    <= stale_next;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign if_valid  = ~fifo_empty;
  assign if_instr  = fifo_empty ? '0 : head.instr;
  assign if_pc     = fifo_empty ? '0 : head.pc;

endmodule
